// File: rtl/alu_result_buffer.sv
// alu_result_buffer: a show-ahead FIFO that buffers ALU results together with
// their condition flags.
// Optional feature macro ALU_RESULT_BUFFER_FLAGS_EN:
//   defined   -> carry/zero/negative are computed at push time, stored with
//                each entry and presented alongside the head data.
//   undefined -> no flag storage is built and the flag outputs read 0.
// The data path and the handshake are identical in both builds.
module alu_result_buffer #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W:0]               in_result,
    input  logic [2:0]               in_alop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_result,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_data;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [W-1:0]            hold_data;
    logic                    push;
    logic                    pop;

    // The handshake depends only on occupancy: in_ready never looks at out_ready.
    always_comb begin
        in_ready  = (count != FULL);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Data storage needs no reset; only the slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem_data[wr_ptr] <= in_result[W-1:0];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember the entry leaving the head so the outputs hold it once empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   hold_data <= '0;
        else if (pop) hold_data <= mem_data[rd_ptr];
    end

    // Show-ahead head: straight from storage while occupied, held value otherwise.
    always_comb begin
        out_result = out_valid ? mem_data[rd_ptr] : hold_data;
    end

`ifdef ALU_RESULT_BUFFER_FLAGS_EN
    // Flags packed as {carry, zero, neg}.
    logic [DEPTH-1:0][2:0] mem_flags;
    logic [2:0]            flags_in;
    logic [2:0]            hold_flags;
    logic [2:0]            head_flags;

    // Carry is only meaningful for the two arithmetic opcodes.
    always_comb begin
        flags_in[2] = ((in_alop == 3'b110) || (in_alop == 3'b101)) ? in_result[W] : 1'b0;
        flags_in[1] = (in_result[W-1:0] == '0);
        flags_in[0] = in_result[W-1];
    end

    // Flags are written alongside the data slot.
    always_ff @(posedge clk) begin
        if (push) mem_flags[wr_ptr] <= flags_in;
    end

    // Flag copy of the departing head, for the empty-hold behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   hold_flags <= '0;
        else if (pop) hold_flags <= mem_flags[rd_ptr];
    end

    // Head flags follow the same selection as the head data.
    always_comb begin
        head_flags = out_valid ? mem_flags[rd_ptr] : hold_flags;
        out_carry  = head_flags[2];
        out_zero   = head_flags[1];
        out_neg    = head_flags[0];
    end
`else
    // Without flags, the opcode and carry-out bit have no consumer.
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_alop, in_result[W]};
    assign out_carry = 1'b0;
    assign out_zero  = 1'b0;
    assign out_neg   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: queue-based reference model,
// per-cycle compare at the falling edge, directed scenarios with literal
// expectations, then randomized traffic.
module tb_alu_result_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W:0]      in_result;
    logic [2:0]      in_alop;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_result;
    logic            out_carry;
    logic            out_zero;
    logic            out_neg;
    logic [CW-1:0]   count;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 0;

`ifdef ALU_RESULT_BUFFER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    alu_result_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_alop(in_alop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_zero(out_zero), .out_neg(out_neg),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each entry is {carry, zero, neg, data}.
    typedef struct { logic [W-1:0] d; logic c; logic z; logic n; } ent_t;
    ent_t q[$];
    ent_t hold;

    function automatic ent_t mk(input logic [W:0] r, input logic [2:0] op);
        ent_t e;
        e.d = r[W-1:0];
        e.c = FLAGS && (op == 3'b110 || op == 3'b101) && r[W];
        e.z = FLAGS && (r[W-1:0] == 0);
        e.n = FLAGS && r[W-1];
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            hold = '{d: '0, c: 1'b0, z: 1'b0, n: 1'b0};
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() > 0);
            if (do_pop)  hold = q.pop_front();
            if (do_push) q.push_back(mk(in_result, in_alop));
        end
    end

    // Compare every cycle away from the rising edge.
    always @(negedge clk) begin
        if (!done) begin
            ent_t h;
            h = (q.size() > 0) ? q[0] : hold;
            chk("count",     64'(count),     64'(q.size()));
            chk("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("out_result",64'(out_result),64'(h.d));
            chk("out_carry", 64'(out_carry), 64'(h.c));
            chk("out_zero",  64'(out_zero),  64'(h.z));
            chk("out_neg",   64'(out_neg),   64'(h.n));
        end
    end

    task automatic drive(input bit iv, input logic [W:0] d, input logic [2:0] op, input bit ordy);
        in_valid = iv; in_result = d; in_alop = op; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] held;
        rst_n = 1'b0;
        drive(0, '0, 3'b000, 0);
        step(); step();
        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_result",64'(out_result),64'd0);
        chk("rst_flags",     64'({out_carry, out_zero, out_neg}), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic transfer with carry-out
        drive(1, 33'h1_0000_0000, 3'b110, 0); step();
        drive(0, '0, 3'b000, 0);
        chk("basic_valid",  64'(out_valid),  64'd1);
        chk("basic_result", 64'(out_result), 64'd0);
        chk("basic_carry",  64'(out_carry),  64'(FLAGS));
        chk("basic_zero",   64'(out_zero),   64'(FLAGS));
        chk("basic_neg",    64'(out_neg),    64'd0);
        chk("basic_count",  64'(count),      64'd1);
        drive(0, '0, 3'b000, 1); step();

        // Fill to full, drop the overflow push, drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1, 33'(i), 3'b000, 0); step();
        end
        chk("full_count", 64'(count),    64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        drive(1, 33'd5, 3'b000, 0); step();
        chk("full_drop_count", 64'(count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(out_result), 64'(i));
            drive(0, '0, 3'b000, 1); step();
        end
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Simultaneous push/pop at count=2, long enough to wrap pointers
        drive(1, 33'd10, 3'b000, 0); step();
        drive(1, 33'd11, 3'b000, 0); step();
        for (int k = 0; k < 10; k++) begin
            chk("pp_head", 64'(out_result), 64'(10 + k));
            drive(1, 33'(12 + k), 3'b000, 1); step();
            chk("pp_count", 64'(count), 64'd2);
        end
        drive(0, '0, 3'b000, 1);
        chk("pp_tail0", 64'(out_result), 64'd20); step();
        chk("pp_tail1", 64'(out_result), 64'd21); step();

        // Negative flag
        drive(1, 33'h0_8000_0000, 3'b001, 0); step();
        drive(0, '0, 3'b000, 0);
        chk("flag_neg",   64'(out_neg),   64'(FLAGS));
        chk("flag_carry", 64'(out_carry), 64'd0);
        chk("flag_zero",  64'(out_zero),  64'd0);
        drive(0, '0, 3'b000, 1); step();

        // Mid-operation reset at count=3
        for (int i = 0; i < 3; i++) begin
            drive(1, 33'(40 + i), 3'b000, 0); step();
        end
        drive(0, '0, 3'b000, 0);
        chk("mr_pre_count", 64'(count), 64'd3);
        rst_n = 1'b0; #2;
        chk("mr_count", 64'(count),     64'd0);
        chk("mr_valid", 64'(out_valid), 64'd0);
        #3 rst_n = 1'b1;
        step();
        drive(1, 33'd7, 3'b000, 0); step();
        drive(0, '0, 3'b000, 1);
        chk("mr_first", 64'(out_result), 64'd7);
        step();

        // Pop while empty
        drive(0, '0, 3'b000, 1);
        held = out_result;
        chk("empty_hold_pre", 64'(held), 64'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("empty_count",  64'(count),      64'd0);
            chk("empty_result", 64'(out_result), 64'(held));
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 99) < 60), {1'($urandom), 32'($urandom_range(0, 3) == 0 ? 0 : $urandom)},
                  op, ($urandom_range(0, 99) < 50));
            if (i % 700 == 350) begin
                rst_n = 1'b0; #3 rst_n = 1'b1;
            end
            step();
        end

        drive(0, '0, 3'b000, 0);
        @(negedge clk);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter W, default 32, ALU data width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream ALU result is valid.
REQ-006 SHALL have port in_ready, output, 1, buffer accepts a result this cycle.
REQ-007 SHALL have port in_result, input, W+1, ALU result; bit W is carry-out.
REQ-008 SHALL have port in_alop, input, 3, opcode that produced in_result.
REQ-009 SHALL have port out_valid, output, 1, head entry available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the head entry.
REQ-011 SHALL have port out_result, output, W, head entry data bits W-1:0.
REQ-012 SHALL have port out_carry, output, 1, head entry carry flag.
REQ-013 SHALL have port out_zero, output, 1, head entry zero flag.
REQ-014 SHALL have port out_neg, output, 1, head entry negative flag.
REQ-015 SHALL have port count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-016 SHALL push on a clk edge when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH); in_ready SHALL NOT depend on out_ready.
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL present the head entry combinationally from storage (show-ahead); a pushed entry becomes visible one cycle after the push edge.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH.
REQ-022 SHALL compute flags at push time and store them with the entry. Carry SHALL be in_result[W] when in_alop is 3'b110 or 3'b101, else 0. Zero SHALL be (in_result[W-1:0] == 0). Neg SHALL be in_result[W-1].
REQ-023 SHALL ignore in_valid while full; the upstream source is responsible for holding its data.
REQ-024 SHALL ignore out_ready while empty, with no underflow and count remaining 0.
REQ-025 SHALL hold out_result and the flags at their last head value while empty, and SHALL keep them stable while out_valid && !out_ready.
REQ-026 SHALL preserve FIFO ordering across pointer wrap-around.

Reset
REQ-027 SHALL, while rst_n = 0, clear both pointers and count and drive out_valid=0, in_ready=1, out_result=0, out_carry=0, out_zero=0, out_neg=0.
REQ-028 SHALL discard all stored entries on reset assertion mid-operation; the first push after rst_n deassertion SHALL be the first entry popped.
REQ-029 SHALL NOT require storage array contents to be reset.

Configuration
REQ-030 SHALL honour macro ALU_RESULT_BUFFER_FLAGS_EN.
- Defined: flags are computed, stored and output per REQ-022.
- Undefined: no flag storage is built, and out_carry, out_zero and out_neg are tied to 0.
- Data path and handshake SHALL be identical in both builds.

Verification
REQ-031 SHALL cover basic transfer: push in_result=33'h1_0000_0000 with in_alop=110 and out_ready=0 -> next cycle out_valid=1, out_result=0, out_carry=1, out_zero=1, out_neg=0, count=1.
REQ-032 SHALL cover fill to full: 4 pushes of 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; a 5th push of 5 is dropped; draining yields 1,2,3,4, then out_valid=0.
REQ-033 SHALL cover simultaneous push and pop at count=2 -> count stays 2 and order is preserved, including across 10 consecutive cycles that force pointer wrap.
REQ-034 SHALL cover flags: push 32'h8000_0000 with in_alop=001 -> out_neg=1, out_carry=0, out_zero=0; without the macro, all three flags read 0.
REQ-035 SHALL cover mid-operation reset: rst_n pulled low for half a cycle at count=3 -> count=0 and out_valid=0 immediately; the next push of 7 pops first as 7.
REQ-036 SHALL cover pop while empty: out_ready=1 for 5 cycles at count=0 -> count stays 0 and out_result is unchanged.
